// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter (5..9 data bits, none/even/odd parity, 1 or 2 stop bits)
// fed by a small valid/ready input FIFO; queued frames are sent back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 5000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    input  logic [DATA_BITS-1:0]            s_data,
    output logic                            s_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            tx_busy,
    output logic                            tx_pin
);

    localparam int CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W       = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || CLK_PER_BIT < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return (PARITY == 2) ? ~(^word) : ^word;
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 load;

    state_t               state;
    state_t               state_nx;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_nx;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_nx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nx;
    logic                 par_bit;
    logic                 par_nx;
    logic                 pin_nx;
    logic                 bit_end;

    assign s_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];
    assign bit_end = (baud_cnt == BAUD_W'(CLK_PER_BIT - 1));
    assign tx_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        par_nx   = par_bit;
        load     = 1'b0;
        baud_nx  = (state == ST_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_nx = ST_DATA;
                    bit_nx   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_nx = shreg >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_nx   = '0;
                        state_nx = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_nx = ST_STOP;
                    bit_nx   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Last stop cycle chains straight into the next start bit when work is queued
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        if (fifo_count != '0) load = 1'b1;
                        else                  state_nx = ST_IDLE;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (load) begin
            state_nx = ST_START;
            bit_nx   = '0;
            shreg_nx = head;
            par_nx   = parity_of(head);
        end
        // The pin is registered from the next state so it changes on the same edge as the FSM
        case (state_nx)
            ST_START:  pin_nx = 1'b0;
            ST_DATA:   pin_nx = shreg_nx[0];
            ST_PARITY: pin_nx = par_nx;
            default:   pin_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_pin   <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            tx_pin   <= pin_nx;
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= shreg_nx;
        par_bit <= par_nx;
    end

endmodule
